// File: rtl/alu_pkg.sv
// Shared constants and opcode encodings for the RISC_YAVA SIMD ALU.
package alu_pkg;

  localparam int unsigned DATA_W    = 256;
  localparam int unsigned SCALAR_W  = 32;
  localparam int unsigned LANE_W    = 16;
  localparam int unsigned NUM_LANES = DATA_W / LANE_W;
  localparam int unsigned OP_W      = 3;

  // Scalar and vector modes reuse the same 3-bit codes with different meanings.
  typedef enum logic [OP_W-1:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SHL = 3'b101,
    OP_SHR = 3'b110,
    OP_SLT = 3'b111
  } scalar_op_e;

  typedef enum logic [OP_W-1:0] {
    OP_VADD   = 3'b000,
    OP_VSUB   = 3'b001,
    OP_VAND   = 3'b010,
    OP_VMUL   = 3'b011,
    OP_VXOR   = 3'b100,
    OP_VROT   = 3'b101,
    OP_VSHR   = 3'b110,
    OP_VPASSB = 3'b111
  } vector_op_e;

endpackage

// File: rtl/simd_alu_lane.sv
// One 16-bit vector lane datapath; purely combinational, no carry in or out.
module simd_alu_lane
  import alu_pkg::*;
(
  input  logic [LANE_W-1:0] a,
  input  logic [LANE_W-1:0] b,
  input  logic [OP_W-1:0]   op,
  output logic [LANE_W-1:0] y_c
);

  logic [3:0] amt;
  assign amt = b[3:0];

  always_comb begin
    y_c = '0;
    unique case (vector_op_e'(op))
      OP_VADD:   y_c = a + b;
      OP_VSUB:   y_c = a - b;
      OP_VAND:   y_c = a & b;
      OP_VMUL:   y_c = a * b;
      OP_VXOR:   y_c = a ^ b;
      // Right shift by 16 yields zero, so a zero rotate returns a unchanged.
      OP_VROT:   y_c = (a << amt) | (a >> (5'd16 - 5'(amt)));
      OP_VSHR:   y_c = a >> amt;
      OP_VPASSB: y_c = b;
      default:   y_c = '0;
    endcase
  end

endmodule

// File: rtl/simd_alu.sv
// Registered 256-bit ALU: one 32-bit scalar op or sixteen independent 16-bit lane ops.
module simd_alu
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  output logic [DATA_W-1:0] Result,
  input  logic [OP_W-1:0]   ALUControl,
  input  logic              RegFileSelect
);

  logic [SCALAR_W-1:0] sa;
  logic [SCALAR_W-1:0] sb;
  logic [SCALAR_W-1:0] scalar_c;
  logic [DATA_W-1:0]   vector_c;
  logic [DATA_W-1:0]   result_d;
  logic [DATA_W-1:0]   result_q;

  assign sa = A[SCALAR_W-1:0];
  assign sb = B[SCALAR_W-1:0];

  // Scalar unit on the low 32 bits.
  always_comb begin
    scalar_c = '0;
    unique case (scalar_op_e'(ALUControl))
      OP_ADD:  scalar_c = sa + sb;
      OP_SUB:  scalar_c = sa - sb;
      OP_AND:  scalar_c = sa & sb;
      OP_OR:   scalar_c = sa | sb;
      OP_XOR:  scalar_c = sa ^ sb;
      OP_SHL:  scalar_c = sa << sb[4:0];
      OP_SHR:  scalar_c = sa >> sb[4:0];
      OP_SLT:  scalar_c = SCALAR_W'(sa < sb);
      default: scalar_c = '0;
    endcase
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    simd_alu_lane u_lane (
      .a   (A[i*LANE_W +: LANE_W]),
      .b   (B[i*LANE_W +: LANE_W]),
      .op  (ALUControl),
      .y_c (vector_c[i*LANE_W +: LANE_W])
    );
  end

  always_comb begin
    result_d = '0;
    if (RegFileSelect) begin
      result_d = vector_c;
    end else begin
      result_d[SCALAR_W-1:0] = scalar_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
    end else begin
      result_q <= result_d;
    end
  end

  assign Result = result_q;

endmodule

// File: tb/tb_simd_alu.sv
// Directed table-driven bench for simd_alu plus reset corner-case sequences.
module tb_simd_alu;

  logic         clk;
  logic         rst_n;
  logic [255:0] A;
  logic [255:0] B;
  logic [255:0] Result;
  logic [2:0]   ALUControl;
  logic         RegFileSelect;

  int checks = 0;
  int errors = 0;

  simd_alu dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .A             (A),
    .B             (B),
    .Result        (Result),
    .ALUControl    (ALUControl),
    .RegFileSelect (RegFileSelect)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic         mode;
    logic [2:0]   op;
    logic [255:0] a;
    logic [255:0] b;
    logic [255:0] exp;
  } vec_t;

  localparam int NV = 26;
  vec_t tbl [NV];

  function automatic vec_t mk(input string n, input logic m, input logic [2:0] o,
                              input logic [255:0] a, input logic [255:0] b,
                              input logic [255:0] e);
    vec_t v;
    v.name = n; v.mode = m; v.op = o; v.a = a; v.b = b; v.exp = e;
    return v;
  endfunction

  task automatic check(input string n, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, got, exp);
    end
  endtask

  task automatic apply(input logic m, input logic [2:0] o,
                       input logic [255:0] a, input logic [255:0] b);
    RegFileSelect = m; ALUControl = o; A = a; B = b;
  endtask

  logic [255:0] ops_a, ops_b, ones, rep1234, rep3, rep8000, repf, repffff, rep1;
  logic [255:0] rep8001, rep0003;

  initial begin
    ops_a   = 256'h0001_0008;
    ops_b   = 256'h0000_8004;
    ones    = '1;
    rep1234 = {16{16'h1234}};
    rep3    = {16{16'h0003}};
    rep8000 = {16{16'h8000}};
    repf    = {16{16'h000F}};
    repffff = {16{16'hFFFF}};
    rep1    = {16{16'h0001}};
    rep8001 = {16{16'h8001}};
    rep0003 = {16{16'h0003}};

    tbl[0]  = mk("s_add",      1'b0, 3'b000, ops_a, ops_b, 256'h0001_800C);
    tbl[1]  = mk("s_sub",      1'b0, 3'b001, ops_a, ops_b, 256'h0000_8004);
    tbl[2]  = mk("s_and",      1'b0, 3'b010, ops_a, ops_b, 256'h0);
    tbl[3]  = mk("s_or",       1'b0, 3'b011, ops_a, ops_b, 256'h0001_800C);
    tbl[4]  = mk("s_xor",      1'b0, 3'b100, ops_a, ops_b, 256'h0001_800C);
    tbl[5]  = mk("s_shl",      1'b0, 3'b101, ops_a, ops_b, 256'h0010_0080);
    tbl[6]  = mk("s_shr",      1'b0, 3'b110, ops_a, ops_b, 256'h0000_1000);
    tbl[7]  = mk("s_slt_0",    1'b0, 3'b111, ops_a, ops_b, 256'h0);
    tbl[8]  = mk("s_slt_1",    1'b0, 3'b111, ops_b, ops_a, 256'h1);
    tbl[9]  = mk("s_add_wrap", 1'b0, 3'b000, ones, 256'h1, 256'h0);
    tbl[10] = mk("s_sub_wrap", 1'b0, 3'b001, 256'h0, 256'h1, 256'hFFFF_FFFF);
    tbl[11] = mk("s_or_upper", 1'b0, 3'b011, ones, ones, 256'hFFFF_FFFF);
    tbl[12] = mk("v_add",      1'b1, 3'b000, ops_a, ops_b, 256'h0001_800C);
    tbl[13] = mk("v_sub",      1'b1, 3'b001, ops_a, ops_b, 256'h0001_8004);
    tbl[14] = mk("v_and",      1'b1, 3'b010, ops_a, ops_b, 256'h0);
    tbl[15] = mk("v_mul",      1'b1, 3'b011, ops_a, ops_b, 256'h0000_0020);
    tbl[16] = mk("v_xor",      1'b1, 3'b100, ops_a, ops_b, 256'h0001_800C);
    tbl[17] = mk("v_rot",      1'b1, 3'b101, ops_a, ops_b, 256'h0001_0080);
    tbl[18] = mk("v_shr",      1'b1, 3'b110, ops_a, ops_b, 256'h0001_0000);
    tbl[19] = mk("v_passb",    1'b1, 3'b111, ops_a, ops_b, 256'h0000_8004);
    tbl[20] = mk("v_add_wrap", 1'b1, 3'b000, repffff, rep1, 256'h0);
    tbl[21] = mk("v_mul_all",  1'b1, 3'b011, rep1234, rep3, {16{16'h369C}});
    tbl[22] = mk("v_rot_all",  1'b1, 3'b101, rep1234, rep3, {16{16'h91A0}});
    tbl[23] = mk("v_rot_wrap", 1'b1, 3'b101, rep8001, rep1, rep0003);
    tbl[24] = mk("v_shr_15",   1'b1, 3'b110, rep8000, repf, rep1);
    tbl[25] = mk("v_sub_all",  1'b1, 3'b001, rep1, rep3, {16{16'hFFFE}});

    rst_n = 1'b0;
    apply(1'b0, 3'b000, ops_a, ops_b);
    #1;
    check("reset_init", Result, 256'h0);
    // Clock edges while reset is held must not capture.
    @(posedge clk); @(negedge clk);
    check("reset_held", Result, 256'h0);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      apply(tbl[i].mode, tbl[i].op, tbl[i].a, tbl[i].b);
      @(negedge clk);
      check(tbl[i].name, Result, tbl[i].exp);
    end

    // Back-to-back issue: each result appears exactly one edge after its inputs.
    @(negedge clk);
    apply(1'b1, 3'b111, ops_a, rep1234);
    @(negedge clk);
    check("b2b_first", Result, rep1234);
    apply(1'b0, 3'b000, ops_a, ops_b);
    @(negedge clk);
    check("b2b_second", Result, 256'h0001_800C);

    // Asynchronous reset between edges clears a nonzero result immediately.
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", Result, 256'h0);
    @(negedge clk);
    check("async_reset_held", Result, 256'h0);
    rst_n = 1'b1;
    apply(1'b0, 3'b000, ops_a, ops_b);
    @(negedge clk);
    check("post_reset_add", Result, 256'h0001_800C);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
